reload_timer_n: RTL

Parametrised successor to the 8-bit reloadable counter/register pair. It holds a programmable reload value and runs a WIDTH-bit counter that counts up or down between 0 and that value. The counter advances on a programmable prescaler tick and supports periodic or one-shot operation. It raises a single-cycle terminal-count pulse and feeds timing/event logic in the same designs that used the 8-bit version.

---
 rtl/reload_timer_n_if.sv | 26 ++
 rtl/reload_timer_n.sv | 77 +++++++
 2 files changed

// File: rtl/reload_timer_n_if.sv
// Control/status bundle for reload_timer_n: reload value, run controls and counter outputs.
interface reload_timer_n_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PSC_W = 4
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             re_load;
  logic             en;
  logic             dir;
  logic             one_shot;
  logic [PSC_W-1:0] presc;
  logic [WIDTH-1:0] data_out;
  logic             tc;
  logic             running;

  modport master (
    output load, data_in, re_load, en, dir, one_shot, presc,
    input  data_out, tc, running
  );

  modport slave (
    input  load, data_in, re_load, en, dir, one_shot, presc,
    output data_out, tc, running
  );
endinterface

// File: rtl/reload_timer_n.sv
// Reloadable up/down WIDTH-bit timer with prescaler, periodic or one-shot mode and registered tc pulse.
module reload_timer_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PSC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  reload_timer_n_if.slave bus
);

  typedef enum logic {
    ST_ARMED,
    ST_EXPIRED
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             at_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ARMED;
      count_q  <= '0;
      reload_q <= '0;
      psc_q    <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      psc_q    <= psc_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    psc_d    = psc_q;
    tc_d     = 1'b0;
    reload_d = bus.load ? bus.data_in : reload_q;

    // >= on both compares absorbs a presc or reload value lowered mid-count.
    tick    = bus.en && (state_q == ST_ARMED) && (psc_q >= bus.presc);
    at_term = bus.dir ? (count_q == '0) : (count_q >= reload_q);

    if (bus.re_load) begin
      // reload_d carries the bypass so a coincident load restarts from data_in.
      count_d = bus.dir ? reload_d : '0;
      psc_d   = '0;
      state_d = ST_ARMED;
    end else if (tick) begin
      psc_d = '0;
      if (at_term) begin
        tc_d = 1'b1;
        if (bus.one_shot) begin
          state_d = ST_EXPIRED;
        end else begin
          count_d = bus.dir ? reload_q : '0;
        end
      end else begin
        count_d = bus.dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
      end
    end else if (bus.en && (state_q == ST_ARMED)) begin
      psc_d = psc_q + PSC_W'(1);
    end
  end

  assign bus.data_out = count_q;
  assign bus.tc       = tc_q;
  assign bus.running  = (state_q == ST_ARMED);

endmodule
